// File: rtl/reg_dump_scanner.sv
// reg_dump_scanner: sweeps a processor debug read port across NUM_REGS
// registers, samples each value after SETTLE cycles, streams {index, value}
// words over a valid/ready handshake and keeps a running XOR checksum.
module reg_dump_scanner #(
    parameter int NUM_REGS = 32,
    parameter int SETTLE   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
    localparam logic [4:0]       LAST_IDX = 5'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] settle_cnt;

    logic load_start;
    logic count_down;
    logic capture;
    logic accept;
    logic advance;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the per-cycle datapath strobes and status outputs.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        load_start = 1'b0;
        count_down = 1'b0;
        capture    = 1'b0;
        accept     = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load_start = 1'b1;
                    next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == '0) begin
                    capture    = 1'b1;
                    next_state = ST_EMIT;
                end else begin
                    count_down = 1'b1;
                end
            end
            ST_EMIT: begin
                // out_valid is always high in EMIT, so out_ready alone completes the handshake.
                busy = 1'b1;
                if (out_ready) begin
                    accept = 1'b1;
                    if (out_idx == LAST_IDX) begin
                        next_state = ST_DONE;
                    end else begin
                        advance    = 1'b1;
                        next_state = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Select/settle counter, captured word and checksum; reset also discards a partial dump.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_sel    <= '0;
            settle_cnt <= '0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_data   <= '0;
            checksum   <= '0;
        end else begin
            if (load_start) begin
                reg_sel    <= '0;
                checksum   <= '0;
                settle_cnt <= CNT_INIT;
            end
            if (count_down) begin
                settle_cnt <= settle_cnt - CNT_W'(1);
            end
            if (capture) begin
                out_data  <= reg_data;
                out_idx   <= reg_sel;
                out_valid <= 1'b1;
            end
            if (accept) begin
                checksum  <= checksum ^ out_data;
                out_valid <= 1'b0;
            end
            if (advance) begin
                reg_sel    <= reg_sel + 5'd1;
                settle_cnt <= CNT_INIT;
            end
        end
    end

endmodule
